// File: rtl/cache_sync_pkg.sv
// rtl/cache_sync_pkg.sv - shared state encoding and line size for the cache window
package cache_sync_pkg;

    localparam int CACHE_LINE_BYTES = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2
    } cache_state_e;

endpackage

// File: rtl/cache_sync_single_reg.sv
// rtl/cache_sync_single_reg.sv - load-enabled register with asynchronous clear
module single_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] val_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q <= '0;
        end else if (en_i) begin
            val_q <= d_i;
        end
    end

    assign q_o = val_q;

endmodule

// File: rtl/cache_sync.sv
// rtl/cache_sync.sv - byte window cache: writeback of a dirty line, then refill at the new base
module cache_sync
    import cache_sync_pkg::*;
#(
    parameter int LINE_BYTES = CACHE_LINE_BYTES
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ptr_load,
    input  logic [7:0]                    new_ptr,
    input  logic [$clog2(LINE_BYTES)-1:0] rd_idx,
    output logic [7:0]                    rd_data,
    input  logic                          wr_en,
    input  logic [$clog2(LINE_BYTES)-1:0] wr_idx,
    input  logic [7:0]                    wr_data,
    output logic                          busy,
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [7:0]                    mem_addr,
    output logic [7:0]                    mem_wdata,
    input  logic                          mem_ack,
    input  logic [7:0]                    mem_rdata
);

    localparam int IW = $clog2(LINE_BYTES);

    cache_state_e   state_q, state_d;
    logic [IW-1:0]  cnt_q, cnt_d;
    logic           valid_q, valid_d;
    logic           dirty_q, dirty_d;
    logic [7:0]     line_q [LINE_BYTES];
    logic [7:0]     base_q, pend_q;
    logic           base_en, pend_en;
    logic           line_we;
    logic [IW-1:0]  line_widx;
    logic [7:0]     line_wdata;
    logic           beat_last;

    single_reg #(.WIDTH(8)) u_base_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (base_en),
        .d_i   (pend_q),
        .q_o   (base_q)
    );

    single_reg #(.WIDTH(8)) u_pend_reg (
        .clk   (clk),
        .reset (reset),
        .en_i  (pend_en),
        .d_i   (new_ptr),
        .q_o   (pend_q)
    );

    assign beat_last = (cnt_q == IW'(LINE_BYTES - 1));
    assign rd_data   = line_q[rd_idx];
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        base_en    = 1'b0;
        pend_en    = 1'b0;
        line_we    = 1'b0;
        line_widx  = wr_idx;
        line_wdata = wr_data;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = 8'h00;
        mem_wdata  = 8'h00;
        case (state_q)
            IDLE: begin
                if (wr_en) begin
                    line_we = 1'b1;
                    dirty_d = 1'b1;
                end
                // a same-cycle write counts as dirty so the writeback carries it
                if (ptr_load && !(valid_q && (new_ptr == base_q))) begin
                    pend_en = 1'b1;
                    cnt_d   = '0;
                    state_d = (valid_q && (dirty_q || wr_en)) ? WB : FILL;
                end
            end
            WB: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = base_q + 8'(cnt_q);
                mem_wdata = line_q[cnt_q];
                if (mem_ack) begin
                    cnt_d = beat_last ? '0 : cnt_q + IW'(1);
                    if (beat_last) begin
                        state_d = FILL;
                        dirty_d = 1'b0;
                    end
                end
            end
            FILL: begin
                mem_req  = 1'b1;
                mem_addr = pend_q + 8'(cnt_q);
                if (mem_ack) begin
                    line_we    = 1'b1;
                    line_widx  = cnt_q;
                    line_wdata = mem_rdata;
                    cnt_d      = beat_last ? '0 : cnt_q + IW'(1);
                    if (beat_last) begin
                        base_en = 1'b1;
                        valid_d = 1'b1;
                        dirty_d = 1'b0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            for (int i = 0; i < LINE_BYTES; i++) begin
                line_q[i] <= 8'h00;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            if (line_we) begin
                line_q[line_widx] <= line_wdata;
            end
        end
    end

endmodule

// File: tb/tb_cache_sync.sv
// tb/tb_cache_sync.sv - scoreboard bench: expected memory beats queued at issue, checked by the memory responder
module tb_cache_sync;

    logic       clk = 1'b0;
    logic       reset;
    logic       ptr_load;
    logic [7:0] new_ptr;
    logic [2:0] rd_idx;
    logic [7:0] rd_data;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_data;
    logic       busy;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;

    cache_sync #(.LINE_BYTES(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .ptr_load  (ptr_load),
        .new_ptr   (new_ptr),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data),
        .busy      (busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } beat_t;

    beat_t      exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] tb_mem  [256];
    logic [7:0] shadow  [256];
    logic [7:0] exp_line[8];
    logic       m_valid, m_dirty;
    logic [7:0] m_base;
    int         ack_delay = 0;
    int         wait_cnt  = 0;
    int         beats     = 0;
    int         ack_limit = 1000000;
    int         nbusy;

    function automatic logic [7:0] pat(input logic [7:0] a);
        return (a * 8'd7) ^ 8'hA5;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    // memory responder doubles as the monitor: every requested cycle is compared to the queue head
    always @(negedge clk) begin
        if (mem_req) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_req we=%b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);
                mem_ack   = 1'b1;
                mem_rdata = tb_mem[mem_addr];
            end else begin
                if (mem_we !== exp_q[0].we || mem_addr !== exp_q[0].addr ||
                    (exp_q[0].we && mem_wdata !== exp_q[0].data)) begin
                    errors++;
                    $display("FAIL mem_beat got we=%b addr=%h wdata=%h exp we=%b addr=%h wdata=%h",
                             mem_we, mem_addr, mem_wdata, exp_q[0].we, exp_q[0].addr, exp_q[0].data);
                end
                if (wait_cnt >= ack_delay && beats < ack_limit) begin
                    mem_ack   = 1'b1;
                    mem_rdata = tb_mem[mem_addr];
                    if (mem_we) tb_mem[mem_addr] = mem_wdata;
                    void'(exp_q.pop_front());
                    beats++;
                    wait_cnt = 0;
                end else begin
                    mem_ack = 1'b0;
                    wait_cnt++;
                end
            end
        end else begin
            mem_ack  = 1'b0;
            wait_cnt = 0;
        end
    end

    task automatic model_reset();
        m_valid = 1'b0;
        m_dirty = 1'b0;
        m_base  = 8'h00;
        for (int i = 0; i < 8; i++) exp_line[i] = 8'h00;
    endtask

    task automatic issue_load(input logic [7:0] nb, input logic do_wr,
                              input logic [2:0] widx, input logic [7:0] wdat);
        logic [7:0] a;
        @(negedge clk);
        ptr_load = 1'b1;
        new_ptr  = nb;
        wr_en    = do_wr;
        wr_idx   = widx;
        wr_data  = wdat;
        if (do_wr) begin
            exp_line[widx] = wdat;
            m_dirty = 1'b1;
        end
        if (!(m_valid && nb == m_base)) begin
            if (m_valid && m_dirty) begin
                for (int i = 0; i < 8; i++) begin
                    a = m_base + 8'(i);
                    exp_q.push_back('{we: 1'b1, addr: a, data: exp_line[i]});
                    shadow[a] = exp_line[i];
                end
            end
            for (int i = 0; i < 8; i++) begin
                a = nb + 8'(i);
                exp_q.push_back('{we: 1'b0, addr: a, data: 8'h00});
                exp_line[i] = shadow[a];
            end
            m_base  = nb;
            m_valid = 1'b1;
            m_dirty = 1'b0;
        end
        @(negedge clk);
        ptr_load = 1'b0;
        wr_en    = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int t = 0; t < 400; t++) begin
            if (!busy) break;
            n++;
            @(negedge clk);
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_line(input string name);
        for (int i = 0; i < 8; i++) begin
            rd_idx = 3'(i);
            #1;
            chk(name, {24'd0, rd_data}, {24'd0, exp_line[i]});
        end
    endtask

    task automatic write_byte(input logic [2:0] idx, input logic [7:0] dat);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_idx  = idx;
        wr_data = dat;
        exp_line[idx] = dat;
        m_dirty = 1'b1;
        @(negedge clk);
        wr_en  = 1'b0;
        rd_idx = idx;
        #1;
        chk("rd_after_write", {24'd0, rd_data}, {24'd0, dat});
    endtask

    initial begin
        reset = 1'b1; ptr_load = 1'b0; new_ptr = 8'h00; rd_idx = 3'd0;
        wr_en = 1'b0; wr_idx = 3'd0; wr_data = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            tb_mem[i] = pat(8'(i));
            shadow[i] = pat(8'(i));
        end
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
        chk("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
        reset = 1'b0;
        check_line("rst_line");

        // clean fill of 10..17, one beat per cycle
        issue_load(8'h10, 1'b0, 3'd0, 8'h00);
        wait_idle(nbusy);
        chk("fill10_busy_cycles", nbusy, 32'd8);
        check_line("line10");

        // dirty byte forces writeback of 10..17 before filling 20..27
        write_byte(3'd3, 8'hAA);
        issue_load(8'h20, 1'b0, 3'd0, 8'h00);
        wait_idle(nbusy);
        chk("wb_fill20_busy_cycles", nbusy, 32'd16);
        chk("mem13_written", {24'd0, tb_mem[8'h13]}, 32'h0000_00AA);
        check_line("line20");

        // write and pointer load in the same cycle; fill wraps FC..03
        issue_load(8'hFC, 1'b1, 3'd0, 8'h55);
        wait_idle(nbusy);
        chk("wbwr_fillFC_busy_cycles", nbusy, 32'd16);
        chk("mem20_written", {24'd0, tb_mem[8'h20]}, 32'h0000_0055);
        check_line("lineFC");

        // reload of the current base is a no-op
        issue_load(8'hFC, 1'b0, 3'd0, 8'h00);
        for (int i = 0; i < 6; i++) begin
            chk("noop_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
        end

        // slow memory, writes and loads while busy must be ignored
        write_byte(3'd6, 8'h3C);
        ack_delay = 3;
        issue_load(8'h40, 1'b0, 3'd0, 8'h00);
        for (int t = 0; t < 400; t++) begin
            if (!busy) begin
                wr_en = 1'b0; ptr_load = 1'b0;
                break;
            end
            wr_en    = ~wr_en;
            wr_idx   = 3'(t);
            wr_data  = 8'hEE;
            ptr_load = wr_en;
            new_ptr  = 8'h99;
            @(negedge clk);
        end
        wr_en = 1'b0; ptr_load = 1'b0;
        wait_idle(nbusy);
        ack_delay = 0;
        check_line("line40");

        // clean window: no writeback expected, fill wraps FC..03
        issue_load(8'hFC, 1'b0, 3'd0, 8'h00);
        wait_idle(nbusy);
        chk("clean_fillFC_busy_cycles", nbusy, 32'd8);
        check_line("lineFC_2");

        // reset in the middle of a fill, after four beats
        ack_limit = beats + 4;
        issue_load(8'h80, 1'b0, 3'd0, 8'h00);
        for (int t = 0; t < 100; t++) begin
            if (beats >= ack_limit) break;
            @(negedge clk);
        end
        @(negedge clk);
        chk("midfill_addr", {24'd0, mem_addr}, 32'h0000_0084);
        #2 reset = 1'b1;
        #1 exp_q.delete();
        model_reset();
        @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_mem_req", {31'd0, mem_req}, 32'd0);
        reset = 1'b0;
        ack_limit = 1000000;
        check_line("line_after_abort");

        // valid was cleared, so even base 00 triggers a full fill with no writeback
        issue_load(8'h00, 1'b0, 3'd0, 8'h00);
        wait_idle(nbusy);
        chk("refill_busy_cycles", nbusy, 32'd8);
        check_line("line00");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
